// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int INSTR_W      = 32;
  localparam int PC_STEP      = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular queue of fetched {pc, instr} pairs with a registered head
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fetch_entry_t     head_q, head_d;
  logic             pop_ok, push_ok, mem_we;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = head_q;

  // head_q mirrors mem_q[rd_ptr_q] while non-empty and keeps the last popped entry otherwise
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    mem_we   = push_ok && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (empty && push_ok) begin
        head_d = push_entry;
      end else if (pop_ok) begin
        if (count_q > CNT_W'(1)) begin
          head_d = mem_q[rd_ptr_q + PTR_W'(1)];
        end else if (push_ok) begin
          head_d = push_entry;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC sequencer that holds each address for WAIT_CYCLES before sampling memory
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                WAIT_CYCLES = 1,
  parameter int                DEPTH       = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              q_push, q_pop, q_full, q_empty, space;
  fetch_entry_t      q_entry, q_head;

  assign imem_addr     = pc_q;
  assign out_valid     = !q_empty;
  assign out_pc        = ADDR_W'(q_head.pc);
  assign out_instr     = q_head.instr;
  assign q_pop         = out_valid && out_ready;
  assign space         = !q_full || q_pop;
  assign q_entry.pc    = FETCH_ADDR_W'(pc_q);
  assign q_entry.instr = imem_instr;

  // redirect flushes the queue, so a sample in the same cycle must not be pushed
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    q_push  = 1'b0;
    if (redirect_valid) begin
      state_d = WAIT;
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      cnt_d   = '0;
    end else begin
      case (state_q)
        BOOT: state_d = WAIT;
        WAIT: begin
          if (fetch_en) begin
            if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
              if (space) begin
                q_push = 1'b1;
                pc_d   = pc_q + ADDR_W'(PC_STEP);
                cnt_d  = '0;
              end else begin
                state_d = FULL;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (fetch_en && space) begin
            q_push  = 1'b1;
            pc_d    = pc_q + ADDR_W'(PC_STEP);
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (q_entry),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - directed checks of fetch latency, backpressure, redirect, wrap and reset
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // memory word at address a is 0xA000_0000 + a/4
  assign imem_instr = 32'hA000_0000 + {2'b00, imem_addr[31:2]};

  instr_fetch_ctrl #(
    .ADDR_W      (32),
    .RESET_PC    (32'h0000_0000),
    .WAIT_CYCLES (1),
    .DEPTH       (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset          = 1'b1;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    // reset state, then free-running fetch
    step(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    reset = 1'b0;
    step(2);
    chk("c2_valid", 32'(out_valid), 32'd0);
    step(1);
    chk("c3_valid", 32'(out_valid), 32'd1);
    chk("c3_pc", out_pc, 32'h0);
    chk("c3_instr", out_instr, 32'hA000_0000);
    step(1);
    chk("c4_valid", 32'(out_valid), 32'd0);
    chk("c4_addr", imem_addr, 32'h4);
    step(1);
    chk("c5_valid", 32'(out_valid), 32'd1);
    chk("c5_pc", out_pc, 32'h4);
    chk("c5_instr", out_instr, 32'hA000_0001);
    step(2);
    chk("c7_pc", out_pc, 32'h8);
    chk("c7_instr", out_instr, 32'hA000_0002);

    // backpressure: queue fills, FSM parks on address 8
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    out_ready = 1'b0;
    step(7);
    chk("bp_c7_addr", imem_addr, 32'h8);
    step(2);
    chk("bp_c9_addr", imem_addr, 32'h8);
    chk("bp_c9_pc", out_pc, 32'h0);
    chk("bp_c9_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step(1);
    chk("bp_c10_pc", out_pc, 32'h4);
    chk("bp_c10_addr", imem_addr, 32'hC);
    step(1);
    chk("bp_c11_pc", out_pc, 32'h8);
    chk("bp_c11_instr", out_instr, 32'hA000_0002);
    step(1);
    chk("bp_c12_pc", out_pc, 32'hC);
    chk("bp_c12_instr", out_instr, 32'hA000_0003);
    chk("bp_c12_addr", imem_addr, 32'h10);

    // redirect during WAIT with two entries queued
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    out_ready = 1'b0;
    step(5);
    chk("rd_pre_pc", out_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    step(1);
    redirect_valid = 1'b0;
    chk("rd_flush_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'h40);
    chk("rd_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step(1);
    chk("rd_c2_valid", 32'(out_valid), 32'd0);
    step(1);
    chk("rd_out_valid", 32'(out_valid), 32'd1);
    chk("rd_out_pc", out_pc, 32'h40);
    chk("rd_out_instr", out_instr, 32'hA000_0010);
    out_ready = 1'b0;

    // redirect coinciding with a sample and a handshake
    step(1);
    chk("rs_head_pc", out_pc, 32'h40);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step(1);
    redirect_valid = 1'b0;
    chk("rs_flush_valid", 32'(out_valid), 32'd0);
    chk("rs_addr", imem_addr, 32'h100);
    step(1);
    chk("rs_c2_valid", 32'(out_valid), 32'd0);
    step(1);
    chk("rs_out_valid", 32'(out_valid), 32'd1);
    chk("rs_out_pc", out_pc, 32'h100);
    chk("rs_out_instr", out_instr, 32'hA000_0040);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step(2);
    chk("wr_top_valid", 32'(out_valid), 32'd1);
    chk("wr_top_pc", out_pc, 32'hFFFF_FFFC);
    chk("wr_top_instr", out_instr, 32'hDFFF_FFFF);
    chk("wr_next_addr", imem_addr, 32'h0);
    step(2);
    chk("wr_zero_pc", out_pc, 32'h0);
    chk("wr_zero_instr", out_instr, 32'hA000_0000);

    // fetch disable mid-wait, then reset while parked in FULL
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    out_ready = 1'b0;
    step(3);
    chk("fe_c3_pc", out_pc, 32'h0);
    fetch_en = 1'b0;
    step(5);
    chk("fe_hold_addr", imem_addr, 32'h4);
    chk("fe_hold_pc", out_pc, 32'h0);
    fetch_en = 1'b1;
    step(5);
    chk("fe_full_addr", imem_addr, 32'h8);
    chk("fe_full_instr", out_instr, 32'hA000_0000);
    reset = 1'b1;
    step(1);
    chk("fr_valid", 32'(out_valid), 32'd0);
    chk("fr_instr", out_instr, 32'd0);
    chk("fr_pc", out_pc, 32'd0);
    chk("fr_addr", imem_addr, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    step(2);
    chk("fr_c2_valid", 32'(out_valid), 32'd0);
    step(1);
    chk("fr_c3_valid", 32'(out_valid), 32'd1);
    chk("fr_c3_pc", out_pc, 32'h0);
    chk("fr_c3_instr", out_instr, 32'hA000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and drives the instruction memory address port. Instruction memory is combinational with a long propagation delay, so each address is held for a fixed number of wait cycles before sampling. Sampled {pc, instruction} pairs go into a small output queue consumed by decode through a valid/ready handshake. Supports branch/jump redirect with flush and a fetch-enable gate.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, first fetch address after reset
WAIT_CYCLES, 1, extra cycles address is held before sampling; must be >= ceil(memory delay / clock period)
DEPTH, 2, output queue entries (power of two, >= 2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
imem_addr  out  ADDR_W  address to instruction memory
imem_instr  in  32  instruction data from memory
fetch_en  in  1  1 = fetching allowed
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  ADDR_W  new fetch target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  32  head instruction
out_pc  out  ADDR_W  head PC

Behaviour:
- Reset (sync, active-high; applies from any state, mid-wait included): state=BOOT, pc=RESET_PC, wait counter=0, queue empty; out_valid=0, out_instr=0, out_pc=0, imem_addr=RESET_PC.
- imem_addr = pc in every state; registered, never glitches mid-wait.
- States: BOOT -> WAIT (unconditional, 1 cycle). WAIT: cnt increments each cycle while fetch_en=1 (held when 0). Sample cycle = WAIT with cnt==WAIT_CYCLES and fetch_en=1.
  - Sample cycle with space (count<DEPTH, or count==DEPTH with a pop this cycle): push {pc, imem_instr}, pc<=pc+4, cnt<=0, stay WAIT.
  - Sample cycle without space: -> FULL, pc/cnt held.
  - FULL: address held; when space and fetch_en=1: push {pc, imem_instr}, pc+=4, cnt=0, -> WAIT.
- Latency: counting cycle 0 as first cycle with reset low, WAIT_CYCLES=1: cycle 0 BOOT, cycle 1 WAIT cnt=0, cycle 2 sample, cycle 3 out_valid=1, out_pc=RESET_PC. Throughput: one instruction per WAIT_CYCLES+1 cycles without backpressure.
- Queue: circular, registered; out_* = head entry (no combinational path imem_instr -> out_instr). Pop on out_valid & out_ready. Push and pop same cycle allowed, count unchanged. out_instr/out_pc hold last value while empty.
- Redirect (priority over everything except reset): next cycle queue empty, pc=redirect_pc with bits[1:0] cleared, cnt=0, state=WAIT. Any sample in the same cycle is discarded. A handshake in the same cycle counts as consumed (head accepted before flush).
- PC arithmetic modulo 2^ADDR_W: 0xFFFF_FFFC + 4 -> 0x0000_0000, no flag.
- fetch_en=0: no sample, no pc change; queue still drains; redirect still honoured.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {BOOT, WAIT, FULL}; fetch_entry_t struct {pc[ADDR_W], instr[32]}; INSTR_W=32; PC_STEP=4.
- Sub-module fetch_queue: parameterised DEPTH FIFO of fetch_entry_t with push, pop, flush, count, full, empty, head. instr_fetch_ctrl holds FSM, PC and wait counter only.

Test Plan:
- Reset release, memory words 0..3 = A0,A1,A2,A3, out_ready=1 -> out_valid first high cycle 3 with pc 0/A0; then pc 4/A1 at cycle 5, 8/A2 at cycle 7.
- out_ready=0 -> queue fills with pc 0,4; FSM in FULL, imem_addr=8 held; raise out_ready -> pops 0, 4, then 8 pushed without skipping or duplication.
- Redirect to 0x0000_0043 during WAIT with 2 queued entries -> next cycle out_valid=0, imem_addr=0x40; first output pc 0x40 two cycles later (WAIT_CYCLES=1).
- Redirect in same cycle as sample and a handshake -> sampled entry not output, handshaken entry consumed once, next output is redirect target.
- Redirect to 0xFFFF_FFFC -> outputs pc 0xFFFF_FFFC then 0x0000_0000.
- fetch_en=0 for 5 cycles mid-wait, then reset asserted mid-FULL -> no pushes while disabled; after reset outputs all zero and sequence restarts at RESET_PC with cycle-3 latency.
